// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM states and BCD constants.
package bcd_serial_adder_pkg;

  // Controller states: waiting for operands, adding one digit per cycle, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest legal BCD digit value.
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Correction added to a binary digit sum that overflowed the decimal range.
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_adder_decimal_adder.sv
// Carry-in-free single-digit BCD adder: binary add, then +6 correction when
// the raw sum leaves the decimal range. The decimal carry marks raw sum >= 10.
module decimal_adder
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] raw;
  logic [4:0] corrected;

  // Raw binary sum, decimal carry detection and correction.
  always_comb begin
    raw       = {1'b0, a} + {1'b0, b};
    corrected = raw + {1'b0, BCD_CORR};
    carry     = (raw > {1'b0, BCD_MAX});
    sum       = carry ? corrected[3:0] : raw[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder. Operands are captured on acceptance, then one digit
// per cycle is summed from digit 0 upward; the result is held until consumed.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE, so an
// operand pair and its result never overlap; neither depends combinationally
// on the partner's valid/ready.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  carry_out,
  output logic                  bcd_err,
  output state_e                dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [IW-1:0]   idx_q;
  logic            run_carry_q, carry_q, err_q;

  logic            accept, last_digit, err_in;
  logic [3:0]      pair_sum, digit;
  logic            pair_carry, inc_carry, new_carry;
  logic [4:0]      inc_raw, inc_corr;
  logic [W-1:0]    digit_ext, digit_top;

  assign accept     = in_valid & in_ready;
  assign last_digit = (idx_q == IW'(DIGITS - 1));

  // Digit 0 of the shifting operand registers is always the digit being summed.
  decimal_adder u_digit (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .sum   (pair_sum),
    .carry (pair_carry)
  );

  // Inject the running carry as a decimal increment of the pair sum.
  always_comb begin
    inc_raw   = {1'b0, pair_sum} + {4'd0, run_carry_q};
    inc_corr  = inc_raw + {1'b0, BCD_CORR};
    inc_carry = (inc_raw > {1'b0, BCD_MAX});
    digit     = inc_carry ? inc_corr[3:0] : inc_raw[3:0];
    new_carry = pair_carry | inc_carry;
    digit_ext = W'(digit);
    digit_top = digit_ext << (4 * (DIGITS - 1));
  end

  // Flag any operand digit above 9 at the moment of acceptance.
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_bcd[4*i +: 4] > BCD_MAX || b_bcd[4*i +: 4] > BCD_MAX) err_in = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ADD;
      end
      ADD: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, then shift one digit per ADD cycle. Sum digits
  // enter at the top and reach their final position after DIGITS shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      run_carry_q <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      a_q         <= a_bcd;
      b_q         <= b_bcd;
      idx_q       <= '0;
      run_carry_q <= 1'b0;
      err_q       <= err_in;
    end else if (state_q == ADD) begin
      a_q         <= a_q >> 4;
      b_q         <= b_q >> 4;
      sum_q       <= (sum_q >> 4) | digit_top;
      run_carry_q <= new_carry;
      idx_q       <= idx_q + 1'b1;
      if (last_digit) carry_q <= new_carry;
    end
  end

  assign sum_bcd   = sum_q;
  assign carry_out = carry_q;
  assign bcd_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: directed vectors, expected results queued at
// issue time and checked by an independent output monitor.
module tb_bcd_serial_adder;
  import bcd_serial_adder_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 3;   // {chk_sum, err, carry, sum}

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_bcd, b_bcd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum_bcd;
  logic          carry_out;
  logic          bcd_err;
  state_e        dbg_state;

  logic [EW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_bcd   (sum_bcd),
    .carry_out (carry_out),
    .bcd_err   (bcd_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: actual=sum 0x%0h required=no output", sum_bcd);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (e[W+2]) check("sum_bcd", 32'(sum_bcd), 32'(e[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(e[W]));
        check("bcd_err",   32'(bcd_err),   32'(e[W+1]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Issue one operand pair, queue its expected result, check result latency.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] es, input logic ec, input logic ee,
                      input logic chk_sum);
    int lat;
    int n;
    wait_ready();
    a_bcd    = a;
    b_bcd    = b;
    in_valid = 1'b1;
    exp_q.push_back({chk_sum, ee, ec, es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_bcd    = W'($urandom);
    b_bcd    = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(DIGITS));
    if (out_ready) begin
      n = 0;
      while (out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("out_valid_drop", 32'(out_valid), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_bcd     = '0;
    b_bcd     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_state",     32'(dbg_state), 32'(IDLE));
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum_bcd),   32'd0);
    check("rst_carry",     32'(carry_out), 32'd0);
    check("rst_err",       32'(bcd_err),   32'd0);

    // Directed vectors
    send(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b1);
    send(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h5678, 16'h4444, 16'h0122, 1'b1, 1'b0, 1'b1);
    send(16'h00A0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'h4999, 16'h5001, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Consumer stalls for 5 cycles; result must hold and new operands be ignored.
    out_ready = 1'b0;
    send(16'h2500, 16'h0700, 16'h3200, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      a_bcd    = W'($urandom);
      b_bcd    = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_sum",       32'(sum_bcd),   32'h3200);
      check("hold_carry",     32'(carry_out), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("idle_sum_kept",     32'(sum_bcd),   32'h3200);

    // Reset during the 2nd ADD cycle aborts the operation.
    a_bcd    = 16'h1111;
    b_bcd    = 16'h2222;
    in_valid = 1'b1;
    @(posedge clk); #1;          // accept
    in_valid = 1'b0;
    @(posedge clk); #1;          // first ADD edge
    rst = 1'b1;
    @(posedge clk); #1;          // reset edge in 2nd ADD cycle
    rst = 1'b0;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum",       32'(sum_bcd),   32'd0);
    check("abort_carry",     32'(carry_out), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
